// File: rtl/reduction_sequencer.sv
// Sequences N chunks through an external adder tree and accumulates one scalar per job; optional stall counter under REDUCTION_SEQ_PERF_CNT_EN.
// Latency: result valid the cycle after the last chunk; input ready only in ACCUM; result and state hold while out_ready_i is low.
module reduction_sequencer #(
  parameter int NUM_INPUTS = 8,
  parameter int DATAW      = 8,
  parameter int MAX_CHUNKS = 16,
  parameter int TREE_DATAW = DATAW + $clog2(NUM_INPUTS),
  parameter int ACCW       = TREE_DATAW + $clog2(MAX_CHUNKS),
  parameter int CNTW       = $clog2(MAX_CHUNKS) + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cfg_valid_i,
  output logic                             cfg_ready_o,
  input  logic [CNTW-1:0]                  cfg_num_chunks_i,
  input  logic                             cfg_sign_unsign_ni_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0] in_data_i,
  output logic [NUM_INPUTS-1:0][DATAW-1:0] tree_data_o,
  output logic                             tree_sign_unsign_no,
  input  logic [TREE_DATAW-1:0]            tree_sum_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [ACCW-1:0]                  out_data_o,
  output logic                             busy_o,
  output logic [31:0]                      perf_stall_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] num_q, cnt_q, num_clamped;
  logic            sign_q;
  logic [ACCW-1:0] acc_q, sum_ext;
  logic            cfg_fire, in_fire, last_chunk;

  assign num_clamped = (cfg_num_chunks_i > CNTW'(MAX_CHUNKS)) ? CNTW'(MAX_CHUNKS)
                                                              : cfg_num_chunks_i;
  assign cfg_fire    = (state_q == IDLE) && cfg_valid_i;
  assign in_fire     = (state_q == ACCUM) && in_valid_i;
  assign last_chunk  = (cnt_q == (num_q - CNTW'(1)));
  assign sum_ext     = sign_q ? ACCW'($signed(tree_sum_i)) : ACCW'(tree_sum_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs decode from the registered state only.
  always_comb begin
    state_d             = state_q;
    cfg_ready_o         = 1'b0;
    in_ready_o          = 1'b0;
    out_valid_o         = 1'b0;
    busy_o              = 1'b1;
    tree_data_o         = '0;
    tree_sign_unsign_no = sign_q;
    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cfg_valid_i) begin
          state_d = (num_clamped == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready_o  = 1'b1;
        tree_data_o = in_data_i;
        if (in_valid_i && last_chunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      num_q  <= '0;
      sign_q <= 1'b0;
    end else if (cfg_fire) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      num_q  <= num_clamped;
      sign_q <= cfg_sign_unsign_ni_i;
    end else if (in_fire) begin
      acc_q <= acc_q + sum_ext;
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign out_data_o = acc_q;

`ifdef REDUCTION_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Counts ACCUM cycles where the streamer had nothing to offer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (cfg_fire) begin
      perf_q <= '0;
    end else if ((state_q == ACCUM) && !in_valid_i) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_reduction_sequencer.sv
// Directed bench for reduction_sequencer with a behavioural adder tree standing in for the parent's instance.
module tb_reduction_sequencer;
  localparam int NI = 8;
  localparam int DW = 8;
  localparam int TW = 11;
  localparam int AW = 15;
  localparam int CW = 5;
`ifdef REDUCTION_SEQ_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic                   cfg_valid, cfg_ready, cfg_sign;
  logic [CW-1:0]          cfg_num;
  logic                   in_valid, in_ready;
  logic [NI-1:0][DW-1:0]  in_data, tree_data;
  logic                   tree_sign;
  logic [TW-1:0]          tree_sum;
  logic                   out_valid, out_ready, busy;
  logic [AW-1:0]          out_data;
  logic [31:0]            perf_stall;

  always #5 clk = ~clk;

  reduction_sequencer dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .cfg_valid_i         (cfg_valid),
    .cfg_ready_o         (cfg_ready),
    .cfg_num_chunks_i    (cfg_num),
    .cfg_sign_unsign_ni_i(cfg_sign),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_data_i           (in_data),
    .tree_data_o         (tree_data),
    .tree_sign_unsign_no (tree_sign),
    .tree_sum_i          (tree_sum),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .out_data_o          (out_data),
    .busy_o              (busy),
    .perf_stall_o        (perf_stall)
  );

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < NI; i++) begin
      if (tree_sign) tree_sum = tree_sum + TW'($signed(tree_data[i]));
      else           tree_sum = tree_sum + TW'(tree_data[i]);
    end
  end

  typedef struct {
    logic [CW-1:0] n;
    logic          sgn;
    logic [DW-1:0] elem;
    int            stalls;
    int            hold;
    logic [AW-1:0] exp_res;
    int            exp_lat;
    int            exp_chunks;
  } vec_t;

  vec_t vecs [9];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cfg_ready"}, 64'(cfg_ready), 64'd1);
    check({tag, " in_ready"},  64'(in_ready),  64'd0);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " out_data"},  64'(out_data),  64'd0);
    check({tag, " busy"},      64'(busy),      64'd0);
    check({tag, " tree_data"}, 64'(tree_data), 64'd0);
    check({tag, " perf"},      64'(perf_stall), 64'd0);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic run_job(input vec_t v, input string tag);
    int            cyc, sent, stalls, rdy_cycles;
    logic          seen, sign_ok, data_ok, hold_ok;
    logic [AW-1:0] held;
    cfg_num   = v.n;
    cfg_sign  = v.sgn;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b0;
    cyc        = 1;
    sent       = 0;
    rdy_cycles = 0;
    stalls     = v.stalls;
    seen       = 1'b0;
    sign_ok    = 1'b1;
    data_ok    = 1'b1;
    while (cyc < 100) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (in_ready) rdy_cycles++;
      if (stalls > 0) begin
        in_valid = 1'b0;
        stalls--;
      end else begin
        in_valid = 1'b1;
        in_data  = {NI{v.elem}};
        if (in_ready) sent++;
      end
      #1;
      if (in_ready && (tree_sign !== v.sgn)) sign_ok = 1'b0;
      if (in_ready && (tree_data !== in_data)) data_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check({tag, " out_valid_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"},   64'(cyc), 64'(v.exp_lat));
    check({tag, " result"},    64'(out_data), 64'(v.exp_res));
    check({tag, " chunks"},    64'(sent), 64'(v.exp_chunks));
    check({tag, " in_ready_cycles"}, 64'(rdy_cycles), 64'(v.exp_chunks + v.stalls));
    check({tag, " tree_sign"}, 64'(sign_ok), 64'd1);
    check({tag, " tree_data"}, 64'(data_ok), 64'd1);
    check({tag, " busy_done"}, 64'(busy), 64'd1);
    held    = out_data;
    hold_ok = 1'b1;
    // Offer a descriptor throughout the hold and the output handshake; it must be ignored.
    for (int h = 0; h < v.hold; h++) begin
      out_ready = 1'b0;
      cfg_valid = 1'b1;
      cfg_num   = CW'(1);
      #1;
      if (out_data !== held || cfg_ready !== 1'b0 || out_valid !== 1'b1) hold_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, " hold_stable"}, 64'(hold_ok), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cfg_valid = 1'b0;
    check({tag, " idle_cfg_ready"}, 64'(cfg_ready), 64'd1);
    check({tag, " idle_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " idle_busy"},      64'(busy), 64'd0);
    check({tag, " idle_result_held"}, 64'(out_data), 64'(v.exp_res));
    check({tag, " perf"}, 64'(perf_stall), PERF_ON ? 64'(v.stalls) : 64'd0);
  endtask

  initial begin
    vec_t one;
    //        n      sgn   elem    stl hold exp_res     lat chunks
    vecs[0] = '{5'd4,  1'b0, 8'hFF, 0, 0, 15'd8160,   5,  4};
    vecs[1] = '{5'd2,  1'b1, 8'h80, 0, 0, 15'h7800,   3,  2};
    vecs[2] = '{5'd0,  1'b0, 8'h55, 0, 0, 15'd0,      1,  0};
    vecs[3] = '{5'd20, 1'b0, 8'h01, 0, 0, 15'd128,    17, 16};
    vecs[4] = '{5'd5,  1'b1, 8'hFF, 0, 0, 15'h7FD8,   6,  5};
    vecs[5] = '{5'd1,  1'b1, 8'h7F, 0, 2, 15'd1016,   2,  1};
    vecs[6] = '{5'd3,  1'b0, 8'h02, 4, 5, 15'd48,     8,  3};
    vecs[7] = '{5'd16, 1'b0, 8'hFF, 0, 0, 15'h7F80,   17, 16};
    vecs[8] = '{5'd7,  1'b0, 8'h3C, 0, 1, 15'd3360,   8,  7};

    rst_ni    = 1'b0;
    cfg_valid = 1'b0;
    cfg_num   = '0;
    cfg_sign  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      run_job(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset lands after 2 of 4 chunks, following two starved cycles.
    cfg_num   = 5'd4;
    cfg_sign  = 1'b0;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data  = {NI{8'h10}};
    repeat (2) @(negedge clk);
    check("midjob busy", 64'(busy), 64'd1);
    rst_ni   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    check_reset_outputs("midjob_reset");

    one = '{5'd1, 1'b0, 8'h01, 0, 0, 15'd8, 2, 1};
    run_job(one, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/reduction_sequencer.md
# reduction_sequencer

Sequencing controller for a shared combinational `adder_tree` instance. It accepts a job descriptor giving a chunk count and signedness, then streams that many `NUM_INPUTS`-wide chunks through the tree, one per cycle. Each tree sum is accumulated into a wide accumulator, and one reduced scalar per job is returned over a valid/ready output. It sits between the operand streamer and the post-processing stage. The tree itself is instantiated by the parent and connected through the `tree_*` ports.

## Interface
- `NUM_INPUTS`, 8, tree width in elements; must be a power of 2.
- `DATAW`, 8, bits per input element.
- `MAX_CHUNKS`, 16, maximum chunks per job; must be a power of 2.
- `TREE_DATAW`, `DATAW+$clog2(NUM_INPUTS)`, derived; tree output width.
- `ACCW`, `TREE_DATAW+$clog2(MAX_CHUNKS)`, derived; accumulator and result width.
- `CNTW`, `$clog2(MAX_CHUNKS)+1`, derived; chunk-count width.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset; synchronous, active-low.
- `cfg_valid_i` in 1: job descriptor valid.
- `cfg_ready_o` out 1: descriptor accepted when high together with `cfg_valid_i`.
- `cfg_num_chunks_i` in CNTW: number of chunks in the job.
- `cfg_sign_unsign_ni_i` in 1: 1 = signed (2's complement), 0 = unsigned.
- `in_valid_i` in 1: chunk valid.
- `in_ready_o` out 1: chunk ready.
- `in_data_i` in DATAW × [NUM_INPUTS]: chunk elements.
- `tree_data_o` out DATAW × [NUM_INPUTS]: operands driven to the tree.
- `tree_sign_unsign_no` out 1: signedness driven to the tree.
- `tree_sum_i` in TREE_DATAW: tree result, combinational in the same cycle.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: result ready.
- `out_data_o` out ACCW: reduced job result.
- `busy_o` out 1: high in any state other than IDLE.
- `perf_stall_o` out 32: count of input-starved cycles (see Configuration).

## Operation
- FSM states are IDLE, ACCUM and DONE, held in a registered state.
- Handshake-ready and valid outputs are decoded combinationally from the state only. None depends on its own partner valid or ready.
- **IDLE**
  - `cfg_ready_o=1`.
  - On `cfg_valid_i`, latch `num = min(cfg_num_chunks_i, MAX_CHUNKS)` and latch the sign bit.
  - Clear the accumulator and the chunk counter.
  - If `num==0`, go to DONE; otherwise go to ACCUM.
- **ACCUM**
  - `in_ready_o=1`.
  - `tree_data_o=in_data_i` and `tree_sign_unsign_no` equals the latched sign.
  - On each `in_valid_i`, update `acc <= acc + ext(tree_sum_i)` and `cnt <= cnt+1`.
  - When the handshake carries chunk `num` (`cnt==num-1`), go to DONE.
- **DONE**
  - `out_valid_o=1` and `out_data_o=acc`.
  - On `out_ready_i`, go to IDLE.
  - A new descriptor is accepted only in IDLE, never in the same cycle as the output handshake.
- `ext()` sign-extends `tree_sum_i` to ACCW when signed and zero-extends it when unsigned. The widths guarantee the result never overflows.
- Outside ACCUM, `tree_data_o` is driven to all zeros to suppress toggling.
- `out_data_o` holds `acc` in every state. `acc` is 0 in IDLE after reset and holds the last result otherwise; consumers use it only while `out_valid_o=1`.
- `in_valid_i` while not in ACCUM is ignored; no chunk is consumed.

## Timing
- **Reset:** any rising edge with `rst_ni=0`, in any state including mid-job, forces the following, and the partial job is discarded:
  - state = IDLE
  - acc = 0
  - cnt = 0
  - `perf_stall_o` = 0
- **Outputs after reset:**
  - `cfg_ready_o=1`
  - `in_ready_o=0`
  - `out_valid_o=0`
  - `out_data_o=0`
  - `busy_o=0`
  - `tree_data_o=0`
- **Throughput:** one chunk per cycle while `in_valid_i` stays high.
- **Latency:** `out_valid_o` rises the cycle after the last chunk handshake. A job with N chunks and no stalls takes at least N+2 cycles from descriptor accept to the next `cfg_ready_o`.
- **Zero-chunk job:** `out_valid_o=1` with `out_data_o=0` the cycle after the descriptor is accepted.
- **Backpressure:** while `out_valid_o=1` and `out_ready_i=0`, `out_data_o` and the state are held stable.

## Configuration
- Macro `REDUCTION_SEQ_PERF_CNT_EN`.
- **Defined:**
  - `perf_stall_o` is a 32-bit register that increments on every ACCUM cycle with `in_valid_i=0`.
  - It wraps at 2^32.
  - It clears on descriptor accept and on reset.
  - It holds its value in DONE and IDLE.
- **Undefined:** no counter logic is generated and `perf_stall_o` is tied to 0. The port list is identical in both builds.

## Test plan
- Unsigned job with `num=4`, every element 0xFF, no stalls (NUM_INPUTS=8, DATAW=8) -> `out_data_o`=8160 and `out_valid_o` high exactly 5 cycles after the descriptor accept edge.
- Signed job with `num=2`, every element 0x80 -> `out_data_o`=-2048 (ACCW-bit 2's complement) and `tree_sign_unsign_no`=1 throughout ACCUM.
- Descriptor with `num=0` -> `out_valid_o=1` and `out_data_o=0` the next cycle, with no `in_ready_o` pulse; `num=20` clamps to 16 chunks.
- Result held 5 cycles with `out_ready_i=0` -> `out_data_o` stable and `cfg_ready_o=0` until the handshake, then IDLE.
- `rst_ni=0` for one edge after 2 of 4 chunks -> IDLE, `acc=0` and all outputs at reset values. A following 1-chunk job of all 1s returns 8.
- With the macro defined, a 3-chunk job with `in_valid_i` low for 4 ACCUM cycles -> `perf_stall_o`=4. With the macro undefined -> `perf_stall_o`=0.
